// File: rtl/romc_arb_pkg.sv
// -----------------------------------------------------------------------------
// romc_arb_pkg
// Shared definitions for the romc coefficient-ROM arbiter:
//   - ROM geometry (address width, data width, depth)
//   - tag_t: {valid, id} carried alongside each ROM read
//   - clog2(): integer ceiling log2, used to size requester ids
// -----------------------------------------------------------------------------
package romc_arb_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 64;
    localparam int ROM_DEPTH  = 8;

    // Tag id field is sized for the largest supported requester count (8).
    // Narrower configurations zero-extend into it.
    localparam int TAG_ID_W   = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/romc_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// romc_rr_pick
// Pure combinational two-winner round-robin picker.
// Scans req starting at rr_ptr (modulo NREQ); the first set bit wins port 1,
// the second set bit wins port 2.
//
// Ports:
//   req      in   NREQ  request vector
//   rr_ptr   in   ID_W  scan start index
//   gnt      out  NREQ  one-hot or two-hot grant vector
//   pick1    out  ID_W  port-1 winner id   (valid when pick1_v)
//   pick1_v  out  1     port-1 has a winner
//   pick2    out  ID_W  port-2 winner id   (valid when pick2_v)
//   pick2_v  out  1     port-2 has a winner
// -----------------------------------------------------------------------------
module romc_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] pick1,
    output logic            pick1_v,
    output logic [ID_W-1:0] pick2,
    output logic            pick2_v
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        pick1   = '0;
        pick1_v = 1'b0;
        pick2   = '0;
        pick2_v = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req[idx[ID_W-1:0]]) begin
                if (!pick1_v) begin
                    pick1_v                = 1'b1;
                    pick1                  = idx[ID_W-1:0];
                    gnt[idx[ID_W-1:0]]     = 1'b1;
                end else if (!pick2_v) begin
                    pick2_v                = 1'b1;
                    pick2                  = idx[ID_W-1:0];
                    gnt[idx[ID_W-1:0]]     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/romc_arbiter.sv
// -----------------------------------------------------------------------------
// romc_arbiter
// Round-robin arbiter sharing the dual-port coefficient ROM (romc) among NREQ
// requesters. Up to two requesters are granted per cycle, one per ROM port.
// Read data returns ROM_LAT cycles after the grant, tagged with the owner id.
//
// Optional build macro: ROMC_ARB_STATS_EN
//   defined   -> conflict_cnt counts cycles with more than two requesters,
//                saturating at 16'hFFFF
//   undefined -> conflict_cnt is constant zero, no counter present
//
// Ports:
//   clk           in   1          system clock
//   reset         in   1          asynchronous active-high reset
//   req           in   NREQ       per-requester read request (level)
//   addr          in   NREQ*3     packed addresses, requester i at [3i+2:3i]
//   gnt           out  NREQ       combinational grant
//   rom_addr1/2   out  3          ROM port addresses
//   rom_dout1/2   in   64         ROM port read data
//   rvalid1/2     out  1          read data valid per port
//   rid1/2        out  ID_W       owner id of the returned data
//   rdata1/2      out  64         returned read data
//   busy          out  1          any read in flight
//   conflict_cnt  out  16         contention statistics counter
// -----------------------------------------------------------------------------
module romc_arbiter
    import romc_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ID_W    = clog2(NREQ),
    parameter int ROM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*ROM_ADDR_W-1:0] addr,
    output logic [NREQ-1:0]            gnt,
    output logic [ROM_ADDR_W-1:0]      rom_addr1,
    output logic [ROM_ADDR_W-1:0]      rom_addr2,
    input  logic [ROM_DATA_W-1:0]      rom_dout1,
    input  logic [ROM_DATA_W-1:0]      rom_dout2,
    output logic                       rvalid1,
    output logic [ID_W-1:0]            rid1,
    output logic [ROM_DATA_W-1:0]      rdata1,
    output logic                       rvalid2,
    output logic [ID_W-1:0]            rid2,
    output logic [ROM_DATA_W-1:0]      rdata2,
    output logic                       busy,
    output logic [15:0]                conflict_cnt
);

    // ------------------------------------------------------------------
    // Unpack per-requester address fields
    // ------------------------------------------------------------------
    logic [ROM_ADDR_W-1:0] addr_field [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_addr
            assign addr_field[gi] = addr[gi*ROM_ADDR_W +: ROM_ADDR_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] rr_ptr_next;
    logic [NREQ-1:0] pick_gnt;
    logic [ID_W-1:0] pick1;
    logic [ID_W-1:0] pick2;
    logic            pick1_v;
    logic            pick2_v;
    logic            grant1;
    logic            grant2;

    romc_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .gnt     (pick_gnt),
        .pick1   (pick1),
        .pick1_v (pick1_v),
        .pick2   (pick2),
        .pick2_v (pick2_v)
    );

    // No grant may be seen while reset is asserted: a grant the requester
    // believes was accepted would otherwise be silently lost.
    assign grant1 = pick1_v & ~reset;
    assign grant2 = pick2_v & ~reset;
    assign gnt    = reset ? '0 : pick_gnt;

    // Pointer moves past the last granted requester so it loses priority.
    always_comb begin
        logic [ID_W-1:0] last;
        last        = grant2 ? pick2 : pick1;
        rr_ptr_next = rr_ptr_reg;
        if (grant1) begin
            if (int'(last) == NREQ - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = last + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // ROM address mux; an idle port keeps presenting its last address
    // ------------------------------------------------------------------
    logic [ROM_ADDR_W-1:0] addr1_hold_reg;
    logic [ROM_ADDR_W-1:0] addr2_hold_reg;

    assign rom_addr1 = grant1 ? addr_field[pick1] : addr1_hold_reg;
    assign rom_addr2 = grant2 ? addr_field[pick2] : addr2_hold_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr1_hold_reg <= '0;
            addr2_hold_reg <= '0;
        end else begin
            addr1_hold_reg <= rom_addr1;
            addr2_hold_reg <= rom_addr2;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: follows each read through the ROM latency
    // ------------------------------------------------------------------
    tag_t tag1_in;
    tag_t tag2_in;
    tag_t pipe1_reg [ROM_LAT];
    tag_t pipe2_reg [ROM_LAT];
    tag_t tag1_out;
    tag_t tag2_out;

    always_comb begin
        tag1_in       = '0;
        tag2_in       = '0;
        tag1_in.valid = grant1;
        tag2_in.valid = grant2;
        if (grant1) begin
            tag1_in.id = TAG_ID_W'(pick1);
        end
        if (grant2) begin
            tag2_in.id = TAG_ID_W'(pick2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe1_reg[i] <= '0;
                pipe2_reg[i] <= '0;
            end
        end else begin
            pipe1_reg[0] <= tag1_in;
            pipe2_reg[0] <= tag2_in;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe1_reg[i] <= pipe1_reg[i-1];
                pipe2_reg[i] <= pipe2_reg[i-1];
            end
        end
    end

    assign tag1_out = pipe1_reg[ROM_LAT-1];
    assign tag2_out = pipe2_reg[ROM_LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            busy = busy | pipe1_reg[i].valid | pipe2_reg[i].valid;
        end
    end

    // Upper id bits are zero when ID_W is narrower than the tag field.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{tag1_out.id, tag2_out.id};

    // ------------------------------------------------------------------
    // Read return. romc already registers its output, so valid data is
    // passed straight through in the return cycle and captured so that
    // rdata holds the last delivered word while idle.
    // ------------------------------------------------------------------
    logic [ROM_DATA_W-1:0] rdata1_hold_reg;
    logic [ROM_DATA_W-1:0] rdata2_hold_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata1_hold_reg <= '0;
            rdata2_hold_reg <= '0;
        end else begin
            if (tag1_out.valid) begin
                rdata1_hold_reg <= rom_dout1;
            end
            if (tag2_out.valid) begin
                rdata2_hold_reg <= rom_dout2;
            end
        end
    end

    assign rvalid1 = tag1_out.valid;
    assign rid1    = tag1_out.id[ID_W-1:0];
    assign rdata1  = tag1_out.valid ? rom_dout1 : rdata1_hold_reg;

    assign rvalid2 = tag2_out.valid;
    assign rid2    = tag2_out.id[ID_W-1:0];
    assign rdata2  = tag2_out.valid ? rom_dout2 : rdata2_hold_reg;

    // ------------------------------------------------------------------
    // Contention statistics
    // ------------------------------------------------------------------
`ifdef ROMC_ARB_STATS_EN
    logic [ID_W:0] req_pop;
    logic [15:0]   conflict_cnt_reg;

    always_comb begin
        req_pop = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_pop = req_pop + (ID_W+1)'(req[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_reg <= '0;
        end else if ((req_pop > (ID_W+1)'(2)) && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_romc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_romc_arbiter
// Directed bench for romc_arbiter (NREQ=4, ROM_LAT=1) with a behavioural romc
// (8 x 64-bit, registered outputs). Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_romc_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [11:0]  addr;
    logic [3:0]   gnt;
    logic [2:0]   rom_addr1;
    logic [2:0]   rom_addr2;
    logic [63:0]  rom_dout1;
    logic [63:0]  rom_dout2;
    logic         rvalid1;
    logic [1:0]   rid1;
    logic [63:0]  rdata1;
    logic         rvalid2;
    logic [1:0]   rid2;
    logic [63:0]  rdata2;
    logic         busy;
    logic [15:0]  conflict_cnt;

    int n_tests;
    int n_fail;
    int exp_rv;
    int got_rv;

`ifdef ROMC_ARB_STATS_EN
    localparam int EXP_CONFLICTS = 4;
`else
    localparam int EXP_CONFLICTS = 0;
`endif

    romc_arbiter #(
        .NREQ    (4),
        .ID_W    (2),
        .ROM_LAT (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .addr         (addr),
        .gnt          (gnt),
        .rom_addr1    (rom_addr1),
        .rom_addr2    (rom_addr2),
        .rom_dout1    (rom_dout1),
        .rom_dout2    (rom_dout2),
        .rvalid1      (rvalid1),
        .rid1         (rid1),
        .rdata1       (rdata1),
        .rvalid2      (rvalid2),
        .rid2         (rid2),
        .rdata2       (rdata2),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural romc
    function automatic logic [63:0] rom_word(input int i);
        return 64'hBEEF_0000_F00D_0000 ^ (64'(i) * 64'h0001_0203_0405_0607) ^ 64'(i << 40);
    endfunction

    logic [63:0] rom_mem [8];
    initial begin
        for (int i = 0; i < 8; i++) rom_mem[i] = rom_word(i);
    end

    always @(posedge clk) begin
        rom_dout1 <= rom_mem[rom_addr1];
        rom_dout2 <= rom_mem[rom_addr2];
    end

    // Count every returned read outside reset
    always @(negedge clk) begin
        if (!reset) got_rv = got_rv + int'(rvalid1) + int'(rvalid2);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pack(input logic [2:0] a0, input logic [2:0] a1,
                                         input logic [2:0] a2, input logic [2:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // One request cycle followed by the return cycle.
    task automatic txn(input string name, input logic [3:0] r, input logic [11:0] a,
                       input logic [3:0] exp_gnt,
                       input logic v1, input int id1, input int a1,
                       input logic v2, input int id2, input int a2);
        @(posedge clk); #1;
        req  = r;
        addr = a;
        @(negedge clk);
        check({name, ".gnt"}, 64'(gnt), 64'(exp_gnt));
        if (v1) check({name, ".rom_addr1"}, 64'(rom_addr1), 64'(a1));
        if (v2) check({name, ".rom_addr2"}, 64'(rom_addr2), 64'(a2));
        exp_rv = exp_rv + int'(v1) + int'(v2);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        check({name, ".rvalid1"}, 64'(rvalid1), 64'(v1));
        check({name, ".rvalid2"}, 64'(rvalid2), 64'(v2));
        check({name, ".busy"}, 64'(busy), 64'(v1 | v2));
        if (v1) begin
            check({name, ".rid1"}, 64'(rid1), 64'(id1));
            check({name, ".rdata1"}, rdata1, rom_word(a1));
        end
        if (v2) begin
            check({name, ".rid2"}, 64'(rid2), 64'(id2));
            check({name, ".rdata2"}, rdata2, rom_word(a2));
        end
        $display("[TB] txn %s req=%b gnt_exp=%b rid1=%0d rid2=%0d", name, r, exp_gnt, rid1, rid2);
    endtask

    logic [3:0] cont_exp [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_rv  = 0;
        got_rv  = 0;
        cont_exp[0] = 4'b0011;
        cont_exp[1] = 4'b1100;
        cont_exp[2] = 4'b0011;
        cont_exp[3] = 4'b1100;

        // ---------------- Reset state (requests present, nothing granted)
        reset = 1'b1;
        req   = 4'b1111;
        addr  = pack(3'd1, 3'd2, 3'd3, 3'd4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.gnt",       64'(gnt), 64'd0);
        check("rst.rom_addr1", 64'(rom_addr1), 64'd0);
        check("rst.rom_addr2", 64'(rom_addr2), 64'd0);
        check("rst.rvalid1",   64'(rvalid1), 64'd0);
        check("rst.rvalid2",   64'(rvalid2), 64'd0);
        check("rst.rid1",      64'(rid1), 64'd0);
        check("rst.rdata1",    rdata1, 64'd0);
        check("rst.rdata2",    rdata2, 64'd0);
        check("rst.busy",      64'(busy), 64'd0);
        check("rst.cnt",       64'(conflict_cnt), 64'd0);
        $display("[TB] txn reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        req   = '0;

        // ---------------- Reset mid-read
        @(posedge clk); #1;
        req  = 4'b0001;
        addr = pack(3'b010, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        check("midrst.gnt", 64'(gnt), 64'b0001);
        check("midrst.rom_addr1", 64'(rom_addr1), 64'b010);
        #2;
        reset = 1'b1;
        req   = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst.rvalid1",   64'(rvalid1), 64'd0);
            check("midrst.busy",      64'(busy), 64'd0);
            check("midrst.rdata1",    rdata1, 64'd0);
            check("midrst.rom_addr1", 64'(rom_addr1), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst.after_rvalid1", 64'(rvalid1), 64'd0);
        $display("[TB] txn reset_mid_read");

        // ---------------- Full contention from rr_ptr=0
        @(posedge clk); #1;
        req  = 4'b1111;
        addr = pack(3'd4, 3'd5, 3'd6, 3'd7);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("contend.gnt%0d", c), 64'(gnt), 64'(cont_exp[c]));
            @(posedge clk); #1;
        end
        req = '0;
        exp_rv = exp_rv + 8;
        @(negedge clk);
        check("contend.conflict_cnt", 64'(conflict_cnt), 64'(EXP_CONFLICTS));
        $display("[TB] txn full_contention cnt=%0d", conflict_cnt);

        // ---------------- Single requester (rr_ptr=0 -> 3)
        txn("single", 4'b0100, pack(3'd0, 3'd0, 3'b101, 3'd0), 4'b0100,
            1'b1, 2, 5, 1'b0, 0, 0);

        // ---------------- Two requesters (rr_ptr=3 -> 2)
        txn("pair", 4'b0011, pack(3'b000, 3'b111, 3'd0, 3'd0), 4'b0011,
            1'b1, 0, 0, 1'b1, 1, 7);

        // ---------------- Idle port 2 keeps its last address (rr_ptr=2 -> 3)
        txn("hold", 4'b0100, pack(3'd0, 3'd0, 3'd3, 3'd0), 4'b0100,
            1'b1, 2, 3, 1'b0, 0, 0);
        check("hold.rom_addr2", 64'(rom_addr2), 64'd7);

        // ---------------- Wrap-around from rr_ptr=3 (-> 1)
        txn("wrap", 4'b1001, pack(3'd1, 3'd0, 3'd0, 3'd6), 4'b1001,
            1'b1, 3, 6, 1'b1, 0, 1);

        // rr_ptr=1 now: all requesting must grant 1 and 2
        txn("wrap_ptr", 4'b1111, pack(3'd0, 3'd2, 3'd4, 3'd0), 4'b0110,
            1'b1, 1, 2, 1'b1, 2, 4);

        // ---------------- Sweep: each requester reads every address
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 8; a++) begin
                logic [11:0] av;
                av = '0;
                av[r*3 +: 3] = 3'(a);
                txn($sformatf("sweep_r%0d_a%0d", r, a), 4'(1 << r), av, 4'(1 << r),
                    1'b1, r, a, 1'b0, 0, 0);
            end
        end

        @(negedge clk);
        check("rvalid_count", 64'(got_rv), 64'(exp_rv));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/romc_arbiter.md
Name: romc_arbiter

Overview:
- Round-robin arbiter sharing the dual-port coefficient ROM (romc: 8 x 64-bit words, 3-bit addresses, registered outputs) among NREQ requesters.
- Grants up to two requesters per cycle, one per ROM port, and drives romc addr1/addr2.
- Returns dout1/dout2 one cycle later, tagged with the requester id.
- Sits between the DCT row/column engines and romc.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width, equal to clog2(NREQ).
- ROM_LAT, 1, romc read latency in cycles; sets the tag pipeline depth.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester read request (level).
- addr  in  NREQ*3  packed request addresses; requester i uses bits [3i+2:3i].
- gnt  out  NREQ  combinational grant, same cycle as the accepted req.
- rom_addr1  out  3  to romc addr1.
- rom_addr2  out  3  to romc addr2.
- rom_dout1  in  64  from romc dout1.
- rom_dout2  in  64  from romc dout2.
- rvalid1  out  1  port-1 read data valid.
- rid1  out  ID_W  owner of rdata1.
- rdata1  out  64  port-1 read data.
- rvalid2, rid2, rdata2: same as above, for port 2.
- busy  out  1  high while any read is in flight.
- conflict_cnt  out  16  stats counter; see Optional Feature.

Behaviour:
- Reset (async, assert-immediately): gnt=0, rvalid1/2=0, rid1/2=0, rdata1/2=0, rom_addr1/2=0, rr_ptr=0, tag pipeline cleared, busy=0, conflict_cnt=0.
- Reads in flight at reset are discarded and never return rvalid.
- Requester rules:
  - Hold req and addr stable until gnt is seen.
  - A transfer occurs in a cycle where req & gnt are both high.
  - Dropping req before gnt is legal; no grant is issued for it.
- Pick, combinational each cycle:
  - Scan req from rr_ptr upward, modulo NREQ.
  - First set bit: port 1. Second set bit: port 2.
  - Fewer requesters means fewer grants.
- rom_addr1/2 are muxed combinationally from the picked requesters' addr fields.
- An unused port holds its previous address, registered copy; no tag is issued for it.
- Tag pipeline:
  - {valid, id} per port, delayed ROM_LAT cycles.
  - Grant in cycle t gives rvalidN=1, ridN=id, rdataN=rom_doutN in cycle t+ROM_LAT.
  - rdataN is registered only when valid; otherwise it holds.
- rr_ptr update on the clock edge after any grant: (index of last granted requester + 1) mod NREQ. It is unchanged when nothing is granted.
- Fairness: with all NREQ requesting continuously, each requester is granted at least once every ceil(NREQ/2) cycles.
- The same address on both ports is legal; both ports read independently.
- A requester re-asserting req in the cycle after its grant competes normally; there is no back-to-back priority.
- busy = OR of all tag-pipeline valid bits.
- No backpressure on read data: requesters must accept rvalid when it arrives.

Optional Feature:
- Macro ROMC_ARB_STATS_EN.
- Defined:
  - conflict_cnt increments on each cycle where popcount(req) > 2.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined:
  - conflict_cnt is tied to 16'h0000 and no counter logic is present.
  - Port list is unchanged.

Decomposition:
- Package romc_arb_pkg holds:
  - ROM_ADDR_W=3, ROM_DATA_W=64, ROM_DEPTH=8.
  - A typedef for a tag struct {valid, id}.
  - Function clog2.
- Sub-module romc_rr_pick:
  - Pure combinational two-winner round-robin picker.
  - Inputs req, rr_ptr.
  - Outputs gnt vector, pick1/pick2 ids, pick1_v/pick2_v.
- The top module keeps the address mux, tag pipeline, rr_ptr register and stats counter.

Test Plan:
- Reset mid-read:
  - Grant req[0] at addr 3'b010, then assert reset in the following cycle.
  - Required: rvalid1 never asserts; all outputs 0; busy=0.
- Single requester:
  - req=4'b0100, addr[8:6]=3'b101.
  - Required: gnt=4'b0100 same cycle; rom_addr1=3'b101; next cycle rvalid1=1, rid1=2, rdata1=romc word 5; rvalid2=0.
- Two requesters:
  - req=4'b0011 with addresses 3'b000 and 3'b111.
  - Required: gnt=4'b0011; next cycle rid1=0 with word 0, rid2=1 with word 7.
- Full contention:
  - req=4'b1111 held for 4 cycles from rr_ptr=0.
  - Required grants: 0011, 1100, 0011, 1100.
  - conflict_cnt=4 with ROMC_ARB_STATS_EN defined, 0 without.
- Wrap-around:
  - rr_ptr=3, req=4'b1001.
  - Required: port1 to requester 3, port2 to requester 0; rr_ptr becomes 1.
- Sweep:
  - Each requester reads addresses 0..7.
  - Required: every rdata matches the romc contents for the issued address and id; no lost or duplicate rvalid.
